// File: rtl/regfile_2w2r_if.sv
// Register-file access bundle: two write ports, two read indices, read buses and Busy.
interface regfile_2w2r_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWr0;
    logic [ADDR_W-1:0] WriteReg0;
    logic [DATA_W-1:0] WriteData0;
    logic              RegWr1;
    logic [ADDR_W-1:0] WriteReg1;
    logic [DATA_W-1:0] WriteData1;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic              Busy;

    modport master (
        output RegWr0, WriteReg0, WriteData0,
        output RegWr1, WriteReg1, WriteData1,
        output rs, rt,
        input  busA, busB, Busy
    );

    modport slave (
        input  RegWr0, WriteReg0, WriteData0,
        input  RegWr1, WriteReg1, WriteData1,
        input  rs, rt,
        output busA, busB, Busy
    );
endinterface

// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with a hardware clear sequencer run after Reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read buses.
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic           CLK,
    input logic           Reset,
    regfile_2w2r_if.slave bus
);
    // state | meaning
    // CLEAR | zeroing mem[ptr], one entry per edge; Busy=1, writes dropped, reads 0
    // READY | normal read/write operation
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              busyQ;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wrEn0;
    logic              wrEn1;
    logic [DATA_W-1:0] rdA;
    logic [DATA_W-1:0] rdB;

    function automatic logic isZeroIdx(input logic [ADDR_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    assign wrEn0 = bus.RegWr0 && !isZeroIdx(bus.WriteReg0);
    assign wrEn1 = bus.RegWr1 && !isZeroIdx(bus.WriteReg1);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= CLEAR;
            ptr   <= '0;
            busyQ <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + 1'b1;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= READY;
                        busyQ <= 1'b0;
                    end
                end
                READY: begin
                    // Port 1 is assigned last so it wins a same-index collision.
                    if (wrEn0) mem[bus.WriteReg0] <= bus.WriteData0;
                    if (wrEn1) mem[bus.WriteReg1] <= bus.WriteData1;
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busyQ <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rdA = mem[bus.rs];
        rdB = mem[bus.rt];
`ifdef REGFILE_BYPASS_EN
        if (wrEn1 && bus.WriteReg1 == bus.rs)      rdA = bus.WriteData1;
        else if (wrEn0 && bus.WriteReg0 == bus.rs) rdA = bus.WriteData0;
        if (wrEn1 && bus.WriteReg1 == bus.rt)      rdB = bus.WriteData1;
        else if (wrEn0 && bus.WriteReg0 == bus.rt) rdB = bus.WriteData0;
`endif
        if (busyQ || isZeroIdx(bus.rs)) rdA = '0;
        if (busyQ || isZeroIdx(bus.rt)) rdB = '0;
    end

    assign bus.busA = rdA;
    assign bus.busB = rdB;
    assign bus.Busy = busyQ;
endmodule

// File: doc/regfile_2w2r.md
Name:
regfile_2w2r

Overview:
- Next-generation CPU general-purpose register file, parametrised in width and depth.
- Two write ports and two combinational read ports (rs/rt → busA/busB).
- Adds a sequential clear sequencer, so reset zeroes the array in hardware instead of relying on simulation-only initialisation.
- Sits in the decode/writeback stage. The ALU result uses write port 0; the load/multiply return path uses write port 1.

Parameters:
- DATA_W, 32, width of each register and of all data buses.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries (derived, not overridable).
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- RegWr0  input  1  write enable, port 0.
- WriteReg0  input  ADDR_W  write index, port 0.
- WriteData0  input  DATA_W  write data, port 0.
- RegWr1  input  1  write enable, port 1.
- WriteReg1  input  ADDR_W  write index, port 1.
- WriteData1  input  DATA_W  write data, port 1.
- rs  input  ADDR_W  read index A.
- rt  input  ADDR_W  read index B.
- busA  output  DATA_W  read data A (combinational).
- busB  output  DATA_W  read data B (combinational).
- Busy  output  1  high while the clear sequencer runs; writes are dropped and reads return 0.

Behaviour:
- Clock and reset: one clock (CLK), rising edge only. Reset is synchronous, active-high.
- State machine has two states, CLEAR and READY, plus a clear pointer ptr[ADDR_W-1:0].
- Reset=1 at a rising edge:
  - state <= CLEAR, ptr <= 0.
  - No array write on that edge.
  - Busy=1 from the following edge onward.
- CLEAR with Reset=0, each edge:
  - mem[ptr] <= 0, ptr <= ptr+1.
  - When ptr==DEPTH-1, state <= READY.
  - Busy therefore deasserts exactly DEPTH edges after the first edge with Reset=0 (32 for defaults).
- Reset asserted mid-clear or mid-operation: the sequence restarts from ptr=0 and all contents are cleared again.
- While Busy=1:
  - RegWr0/RegWr1 are ignored.
  - busA = busB = 0 regardless of rs/rt.
- Writes in READY:
  - On the rising edge, mem[WriteRegN] <= WriteDataN when RegWrN=1.
  - Written data is visible on the read buses in the cycle after the edge.
- Simultaneous writes to the same index: port 1 wins and the port 0 data is discarded. Writes to different indices both commit in the same edge.
- Zero register, ZERO_REG=1:
  - Writes to index 0 are suppressed on both ports.
  - Reads of index 0 return 0 (also under bypass).
- Reads:
  - busA = mem[rs], busB = mem[rt].
  - Purely combinational, no latency, no handshake.
  - rs==rt is legal; both buses return the same value.
- Power-up state before the first Reset is undefined. Integration must assert Reset for at least 1 cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (READY state only):
  - Same-cycle write-to-read forwarding on each read port independently.
  - If RegWr1 && WriteReg1==rs (and the index is non-zero when ZERO_REG=1), busA = WriteData1.
  - Otherwise, if the same condition holds for port 0, busA = WriteData0.
  - Otherwise busA = mem[rs]. Identical rules apply for busB/rt.
  - Port-1 priority matches the write priority.
- Not defined: read buses show array contents only. A value written at edge N is visible only after edge N.

Test Plan:
- Assert Reset 2 cycles, then release → Busy=1 for exactly 32 edges then 0; every rs/rt in 0..31 reads 0x00000000.
- READY; RegWr0=1, WriteReg0=5, WriteData0=0xDEADBEEF for one edge; rs=5 → busA=0xDEADBEEF after the edge; without the macro, busA=0 in the write cycle.
- Both ports write index 7 in the same edge (port0 0x11111111, port1 0x22222222) → rt=7 gives busB=0x22222222.
- RegWr0=1, WriteReg0=0, data 0xFFFFFFFF; ZERO_REG=1 → busA with rs=0 stays 0; repeat with ZERO_REG=0 → reads 0xFFFFFFFF.
- Fill r1..r31 with distinct values, assert Reset mid-stream for 1 cycle, and attempt a write to r3 while Busy=1 → after Busy falls, all entries read 0 and the r3 write is absent.
- With REGFILE_BYPASS_EN: RegWr1=1, WriteReg1=9, data 0xCAFEF00D, rs=rt=9 in the same cycle → busA=busB=0xCAFEF00D before the edge; Busy=1 case → buses stay 0.
